// File: rtl/ysyx_22050039_reg_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050039_reg_pkg
// Shared project constants for the ysyx_22050039 core.
//   XLEN         : architectural register width
//   PC_RESET_VAL : program counter value after reset
// The generic register module does not import this package. Callers pass
// these values in as parameters, so the register stays reusable on its own.
// ---------------------------------------------------------------------------
package ysyx_22050039_reg_pkg;

  localparam int          XLEN         = 64;
  localparam logic [63:0] PC_RESET_VAL = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22050039_reg.sv
// ---------------------------------------------------------------------------
// ysyx_22050039_reg
// Generic write-enabled register with a synchronous, active-high reset.
//
// Parameters
//   WIDTH     : data width in bits (>= 1)
//   RESET_VAL : value loaded on reset. It is zero-extended or truncated to
//               WIDTH, so 32'h8000_0000 with WIDTH=64 gives 0x0000_0000_8000_0000.
// Ports
//   clk  : clock; every state update happens on the rising edge
//   rst  : synchronous reset, active-high; has priority over wen
//   din  : next value to store
//   dout : current stored value, driven directly from the flop
//   wen  : write enable, active-high; when low the register holds its value
//
// Optional feature
//   YSYX_22050039_REG_TRACE_EN : when this macro is defined, the register
//   prints one simulation line for each accepted write (old and new value)
//   and one line for each reset edge. It has no effect on register behaviour.
// ---------------------------------------------------------------------------
module ysyx_22050039_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  logic [WIDTH-1:0] data_reg;

  // Reset is checked before wen, so reset wins when both are asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= RESET_VAL;
    end else if (wen) begin
      data_reg <= din;
    end
  end

  // dout comes straight from the flop. It has no combinational path from
  // din or rst, so it changes only at rising clock edges.
  assign dout = data_reg;

`ifdef YSYX_22050039_REG_TRACE_EN
  always @(posedge clk) begin
    if (rst) begin
      $display("%m: reset -> %h", RESET_VAL);
    end else if (wen) begin
      $display("%m: write %h -> %h", data_reg, din);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050039_reg.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050039_reg
// Self-checking bench for ysyx_22050039_reg with WIDTH=64 and
// RESET_VAL=32'h8000_0000. The reset literal is 32 bits wide, so this setup
// also checks that the reset value is zero-extended.
// A reference value, model, holds what the register should contain. Each step
// drives inputs at the falling edge and then checks twice:
//   - before the rising edge: dout must still show the old value;
//   - after the rising edge: dout must show the updated model.
// ---------------------------------------------------------------------------
module tb_ysyx_22050039_reg;
  import ysyx_22050039_reg_pkg::*;

  localparam logic [63:0] RST_EXP = 64'h0000_0000_8000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wen = 1'b0;
  logic [XLEN-1:0] din = '0;
  logic [XLEN-1:0] dout;

  logic [63:0] model;
  bit          model_valid = 1'b0;
  int          total_cnt = 0;
  int          bad_cnt   = 0;

  ysyx_22050039_reg #(
    .WIDTH    (XLEN),
    .RESET_VAL(32'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout),
    .wen (wen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Runs one clock transaction and checks dout before and after the edge.
  task automatic step(input string tag, input logic r, input logic w,
                      input logic [63:0] d, input bit use_x);
    @(negedge clk);
    rst = r;
    wen = w;
    if (use_x) din = 'x;
    else       din = d;
    #1;
    if (model_valid) chk({tag, "/pre"}, dout, model);
    @(posedge clk);
    #1;
    if (r) begin
      model = RST_EXP;
      model_valid = 1'b1;
    end else if (w) begin
      model = d;
    end
    if (model_valid) chk({tag, "/post"}, dout, model);
    $display("txn %-10s rst=%0b wen=%0b din=%h dout=%h", tag, r, w, d, dout);
  endtask

  initial begin
    logic [63:0] rd;
    bit          rr;
    bit          rw;

    // Reset with a single rising edge.
    step("reset", 1'b1, 1'b0, 64'h0, 1'b0);
    // Single write.
    step("write", 1'b0, 1'b1, 64'h8000_0004, 1'b0);
    // Hold for three cycles while din changes, including an X value.
    step("hold0", 1'b0, 1'b0, 64'h1234_5678_9abc_def0, 1'b0);
    step("hold1", 1'b0, 1'b0, 64'h0, 1'b1);
    step("hold2", 1'b0, 1'b0, 64'hffff_0000_ffff_0000, 1'b0);
    // Reset has priority over a write in the same cycle.
    step("rst_wen", 1'b1, 1'b1, 64'hdead_beef, 1'b0);
    // Increment sequence: reset, then din = value + 4 every cycle.
    step("seq_rst", 1'b1, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("seq_inc", 1'b0, 1'b1, model + 64'd4, 1'b0);
    end
    chk("seq_final", dout, 64'h0000_0000_8000_000c);
    // All 64 bits are stored, then reset restores the reset value.
    step("ones", 1'b0, 1'b1, 64'hffff_ffff_ffff_ffff, 1'b0);
    chk("ones_full", dout, 64'hffff_ffff_ffff_ffff);
    step("ones_rst", 1'b1, 1'b0, 64'h0, 1'b0);
    chk("ones_rst_val", dout, RST_EXP);

    // Randomized traffic with reset asserted rarely.
    for (int i = 0; i < 100; i++) begin
      rd = {$urandom(), $urandom()};
      rr = ($urandom_range(0, 15) == 0);
      rw = $urandom_range(0, 1) == 1;
      step("rand", rr, rw, rd, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
